// File: rtl/des_pkg.sv
// Shared DES constants: key-schedule permutations, rotation schedule,
// key-schedule FSM encoding and small bit-shuffling helpers.
package des_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ks_state_t;

    // PC1: selects 56 key bits (DES numbering 1..64), C half first.
    localparam logic [5:0] PC1 [0:55] = '{
        6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,  6'd1,
        6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18, 6'd10, 6'd2,
        6'd59, 6'd51, 6'd43, 6'd35, 6'd27, 6'd19, 6'd11, 6'd3,
        6'd60, 6'd52, 6'd44, 6'd36,
        6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15, 6'd7,
        6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22, 6'd14, 6'd6,
        6'd61, 6'd53, 6'd45, 6'd37, 6'd29, 6'd21, 6'd13, 6'd5,
        6'd28, 6'd20, 6'd12, 6'd4
    };

    // PC2: selects 48 bits of the 56-bit CD register (DES numbering 1..56).
    localparam logic [5:0] PC2 [0:47] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28,
        6'd15, 6'd6,  6'd21, 6'd10, 6'd23, 6'd19, 6'd12, 6'd4,
        6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40,
        6'd51, 6'd45, 6'd33, 6'd48, 6'd44, 6'd49, 6'd39, 6'd56,
        6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    // Per-round left rotation amount; index 0 corresponds to round 1.
    localparam logic [1:0] SHIFT [0:15] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // PC1 permutation; DES bit n of the key lives at key[64-n].
    function automatic logic [55:0] pc1_perm(input logic [63:0] key);
        logic [55:0] r;
        r = 56'd0;
        for (int i = 0; i < 56; i++) begin
            r[6'(55 - i)] = key[6'(7'd64 - {1'b0, PC1[i]})];
        end
        return r;
    endfunction

    // 28-bit rotate by 1 or 2 positions, left or right.
    function automatic logic [27:0] rot28(input logic [27:0] x,
                                          input logic [1:0]  amt,
                                          input logic        right);
        logic [27:0] r;
        case ({right, amt})
            3'b001:  r = {x[26:0], x[27]};
            3'b010:  r = {x[25:0], x[27:26]};
            3'b101:  r = {x[0], x[27:1]};
            3'b110:  r = {x[1:0], x[27:2]};
            default: r = x;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational PC2 permutation: 56-bit CD register -> 48-bit round subkey.
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] cd,
    output logic [47:0] subkey
);

    // Gather the 48 selected CD bits; DES bit n of CD sits at cd[56-n].
    always_comb begin
        subkey = 48'd0;
        for (int i = 0; i < 48; i++) begin
            subkey[6'(47 - i)] = cd[6'd56 - PC2[i]];
        end
    end

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: one key in, sixteen subkeys out over a
// valid/ready stream, forward order for encrypt, reverse for decrypt.
module des_key_schedule
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] key_in,
    input  logic        decrypt,
    input  logic        key_valid,
    output logic        key_ready,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  round_idx,
    output logic        last
);

    ks_state_t   state_r;
    ks_state_t   state_next_s;
    logic [55:0] cd_r;
    logic [55:0] cd_next_s;
    logic [55:0] cd_init_s;
    logic [47:0] subkey_r;
    logic [47:0] pc2_s;
    logic [3:0]  round_idx_r;
    logic        dir_r;
    logic        load_s;
    logic        accept_s;
    logic [1:0]  shift_amt_s;
    logic        shift_right_s;
    logic        key_ready_s;
    logic        subkey_valid_s;
    logic        last_s;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: accept a key when idle, leave after the final handshake.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (key_valid) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (subkey_ready && (round_idx_r == 4'd15)) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RUN;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Output decode, purely from registered state and index.
    always_comb begin
        key_ready_s    = 1'b0;
        subkey_valid_s = 1'b0;
        last_s         = 1'b0;
        case (state_r)
            IDLE: begin
                key_ready_s = 1'b1;
            end
            RUN: begin
                subkey_valid_s = 1'b1;
                last_s         = (round_idx_r == 4'd15);
            end
            default: begin
                key_ready_s = 1'b0;
            end
        endcase
    end

    // Next CD value: PC1 of a new key, or one schedule step from the current CD.
    // Decrypt starts on CD0 (equal to CD16) and walks backwards with right rotations.
    always_comb begin
        load_s        = 1'b0;
        accept_s      = 1'b0;
        shift_amt_s   = 2'd0;
        shift_right_s = 1'b0;
        cd_init_s     = pc1_perm(key_in);
        cd_next_s     = cd_r;
        case (state_r)
            IDLE: begin
                if (key_valid) begin
                    load_s      = 1'b1;
                    accept_s    = 1'b1;
                    shift_amt_s = decrypt ? 2'd0 : SHIFT[0];
                    cd_next_s   = {rot28(cd_init_s[55:28], shift_amt_s, 1'b0),
                                   rot28(cd_init_s[27:0],  shift_amt_s, 1'b0)};
                end else begin
                    cd_next_s = cd_r;
                end
            end
            RUN: begin
                if (subkey_ready && (round_idx_r != 4'd15)) begin
                    load_s = 1'b1;
                    if (dir_r) begin
                        shift_amt_s   = SHIFT[4'd15 - round_idx_r];
                        shift_right_s = 1'b1;
                    end else begin
                        shift_amt_s   = SHIFT[round_idx_r + 4'd1];
                        shift_right_s = 1'b0;
                    end
                    cd_next_s = {rot28(cd_r[55:28], shift_amt_s, shift_right_s),
                                 rot28(cd_r[27:0],  shift_amt_s, shift_right_s)};
                end else begin
                    cd_next_s = cd_r;
                end
            end
            default: cd_next_s = cd_r;
        endcase
    end

    des_pc2 u_pc2 (
        .cd     (cd_next_s),
        .subkey (pc2_s)
    );

    // Datapath registers: CD, emitted subkey, sequence position and direction.
    always_ff @(posedge clk) begin
        if (rst) begin
            cd_r        <= 56'd0;
            subkey_r    <= 48'd0;
            round_idx_r <= 4'd0;
            dir_r       <= 1'b0;
        end else if (load_s) begin
            cd_r     <= cd_next_s;
            subkey_r <= pc2_s;
            if (accept_s) begin
                round_idx_r <= 4'd0;
                dir_r       <= decrypt;
            end else begin
                round_idx_r <= round_idx_r + 4'd1;
                dir_r       <= dir_r;
            end
        end else begin
            cd_r        <= cd_r;
            subkey_r    <= subkey_r;
            round_idx_r <= round_idx_r;
            dir_r       <= dir_r;
        end
    end

    assign key_ready    = key_ready_s;
    assign subkey_valid = subkey_valid_s;
    assign last         = last_s;
    assign subkey       = subkey_r;
    assign round_idx    = round_idx_r;

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule against a cumulative-rotation
// reference of the DES key schedule.
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] key_in;
    logic        decrypt;
    logic        key_valid;
    logic        key_ready;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [3:0]  round_idx;
    logic        last;

    always #5 clk = ~clk;

    des_key_schedule dut (
        .clk          (clk),
        .rst          (rst),
        .key_in       (key_in),
        .decrypt      (decrypt),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .round_idx    (round_idx),
        .last         (last)
    );

    int tests = 0;
    int fails = 0;

    int T_PC1 [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                       63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
    int T_PC2 [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                       41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    int T_SHIFT [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;

    // Reference: Ki from C0/D0 rotated left by the cumulative shift count.
    function automatic logic [15:0][47:0] ref_sched(input logic [63:0] key, input bit dec);
        bit kb [1:64];
        bit c0 [1:28];
        bit d0 [1:28];
        bit cd [1:56];
        int s;
        logic [47:0] k;
        logic [15:0][47:0] res;
        for (int i = 1; i <= 64; i++) kb[i] = key[64 - i];
        for (int j = 1; j <= 28; j++) begin
            c0[j] = kb[T_PC1[j - 1]];
            d0[j] = kb[T_PC1[j + 27]];
        end
        s = 0;
        for (int r = 1; r <= 16; r++) begin
            s += T_SHIFT[r - 1];
            for (int j = 1; j <= 28; j++) begin
                cd[j]      = c0[((j - 1 + s) % 28) + 1];
                cd[28 + j] = d0[((j - 1 + s) % 28) + 1];
            end
            k = 48'd0;
            for (int j = 1; j <= 48; j++) k[48 - j] = cd[T_PC2[j - 1]];
            res[dec ? 16 - r : r - 1] = k;
        end
        return res;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Bench-side model of the stream.
    bit                m_busy = 1'b0;
    int                m_pos = 0;
    logic [15:0][47:0] m_keys;
    bit                chk_en = 1'b0;
    bit                after_rst = 1'b0;
    logic [47:0]       seen [$];

    // Compare process: check outputs, then advance the model for the coming edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("key_ready", 64'(key_ready), 64'(!m_busy));
            check("subkey_valid", 64'(subkey_valid), 64'(m_busy));
            if (m_busy) begin
                check("subkey", 64'(subkey), 64'(m_keys[m_pos]));
                check("round_idx", 64'(round_idx), 64'(m_pos));
                check("last", 64'(last), 64'(m_pos == 15));
                if (subkey_ready) seen.push_back(subkey);
            end else begin
                check("last_idle", 64'(last), 64'd0);
                if (after_rst) check("subkey_after_rst", 64'(subkey), 64'd0);
            end
        end
        after_rst = 1'b0;
        if (rst) begin
            m_busy = 1'b0;
            m_pos = 0;
            after_rst = 1'b1;
            chk_en = 1'b1;
        end else if (!m_busy) begin
            if (key_valid) begin
                m_busy = 1'b1;
                m_pos = 0;
                m_keys = ref_sched(key_in, decrypt);
            end
        end else if (subkey_ready) begin
            if (m_pos == 15) m_busy = 1'b0;
            else m_pos++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a key until accepted; returns edges taken. Leaves key_valid as told.
    task automatic send_key(input logic [63:0] key, input bit dec, input bit hold, output int n);
        bit acc;
        key_in = key;
        decrypt = dec;
        key_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        for (int i = 0; i < 100 && !acc; i++) begin
            acc = key_ready;
            tick();
            n++;
        end
        if (!acc) check("key_accept_timeout", 64'd0, 64'd1);
        if (!hold) key_valid = 1'b0;
    endtask

    task automatic wait_done(input int pct);
        for (int i = 0; i < 400 && m_busy; i++) begin
            subkey_ready = ($urandom_range(99) < pct);
            tick();
        end
        if (m_busy) check("job_timeout", 64'd1, 64'd0);
        subkey_ready = 1'b1;
    endtask

    task automatic wait_idx(input logic [3:0] idx);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            if (subkey_valid && round_idx == idx) hit = 1'b1;
            else tick();
        end
        if (!hit) check("wait_idx_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_job(input logic [63:0] key, input bit dec, input int pct);
        int n;
        seen.delete();
        send_key(key, dec, 1'b0, n);
        wait_done(pct);
    endtask

    logic [15:0][47:0] pin;
    logic [47:0]       enc_seq [16];
    int                gap;

    initial begin
        rst = 1'b1;
        key_in = 64'd0;
        decrypt = 1'b0;
        key_valid = 1'b0;
        subkey_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Pin the reference with published values.
        pin = ref_sched(KEY_A, 1'b0);
        check("pin_enc_k1", 64'(pin[0]), 64'h1B02EFFC7072);
        check("pin_enc_k16", 64'(pin[15]), 64'hCB3D8B0E17F5);
        pin = ref_sched(KEY_A, 1'b1);
        check("pin_dec_first", 64'(pin[0]), 64'hCB3D8B0E17F5);

        // Encrypt, free-flowing.
        run_job(KEY_A, 1'b0, 100);
        check("enc_count", 64'(seen.size()), 64'd16);
        for (int i = 0; i < 16; i++) enc_seq[i] = (i < seen.size()) ? seen[i] : 48'd0;
        check("enc_pos0", 64'(enc_seq[0]), 64'h1B02EFFC7072);
        check("enc_pos15", 64'(enc_seq[15]), 64'hCB3D8B0E17F5);

        // Decrypt is the encrypt sequence reversed.
        run_job(KEY_A, 1'b1, 100);
        check("dec_count", 64'(seen.size()), 64'd16);
        for (int i = 0; i < 16 && i < seen.size(); i++)
            check("dec_reverse", 64'(seen[i]), 64'(enc_seq[15 - i]));

        // Parity bits ignored.
        run_job(KEY_A ^ 64'h0101010101010101, 1'b0, 100);
        check("par_count", 64'(seen.size()), 64'd16);
        for (int i = 0; i < 16 && i < seen.size(); i++)
            check("parity", 64'(seen[i]), 64'(enc_seq[i]));

        // Random stalls.
        run_job(KEY_A, 1'b0, 40);
        check("stall_count", 64'(seen.size()), 64'd16);
        for (int i = 0; i < 16 && i < seen.size(); i++)
            check("stall_seq", 64'(seen[i]), 64'(enc_seq[i]));

        // Reset mid-job, then a clean job.
        send_key({$urandom, $urandom}, 1'b0, 1'b0, gap);
        wait_idx(4'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_valid", 64'(subkey_valid), 64'd0);
        check("rst_ready", 64'(key_ready), 64'd1);
        check("rst_subkey", 64'(subkey), 64'd0);
        run_job(KEY_A, 1'b0, 100);
        check("post_rst_count", 64'(seen.size()), 64'd16);
        for (int i = 0; i < 16 && i < seen.size(); i++)
            check("post_rst_seq", 64'(seen[i]), 64'(enc_seq[i]));

        // Key offered while busy is ignored.
        seen.delete();
        send_key(KEY_A, 1'b0, 1'b0, gap);
        wait_idx(4'd3);
        key_in = 64'hFEDCBA9876543210;
        decrypt = 1'b1;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        wait_done(100);
        check("busy_count", 64'(seen.size()), 64'd16);
        for (int i = 0; i < 16 && i < seen.size(); i++)
            check("busy_seq", 64'(seen[i]), 64'(enc_seq[i]));

        // Back-to-back keys with key_valid held.
        send_key({$urandom, $urandom}, 1'b0, 1'b1, gap);
        send_key({$urandom, $urandom}, 1'b1, 1'b0, gap);
        check("b2b_gap", 64'(gap), 64'd17);
        wait_done(100);

        // Randomized jobs.
        for (int j = 0; j < 8; j++) begin
            run_job({$urandom, $urandom}, $urandom_range(1), $urandom_range(100, 30));
            check("rand_count", 64'(seen.size()), 64'd16);
        end

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
